// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM state type and op helpers for muldiv_unit.
// MADD/MADDU/MSUB/MSUBU are only executed when MULDIV_MADD_EN is defined.
package muldiv_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MFHI  = 4'd4;
    localparam logic [3:0] OP_MFLO  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;
    localparam logic [3:0] OP_MSUBU = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIXUP,
        S_ACCUM
    } md_state_t;

    // Ops whose operands are two's-complement.
    function automatic logic op_signed(input logic [3:0] o);
        return (o == OP_MULT) || (o == OP_DIV) ||
               (o == OP_MADD) || (o == OP_MSUB);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: op request / MFHI-MFLO read bus between controller and muldiv_unit.
// master drives the op, slave answers with op_ready and rd_data.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op_ready;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output op_valid, op, a, b,
        input  op_ready, rd_data
    );

    modport slave (
        input  op_valid, op, a, b,
        output op_ready, rd_data
    );
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-step shift-add multiply / restoring divide datapath.
// acc holds {upper, lower}: product, or {remainder, quotient} when dividing.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] acc
);

    logic [WIDTH-1:0] opnd;
    logic             div_mode;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // Candidate next values for one multiply step and one divide step.
    always_comb begin
        addend = acc[0] ? opnd : '0;
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, opnd};
    end

    // Load operands, then advance one bit per step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            div_mode <= is_div;
            opnd     <= is_div ? op_b : op_a;
            acc      <= is_div ? {{WIDTH{1'b0}}, op_a}
                               : {{WIDTH{1'b0}}, op_b};
        end else if (step) begin
            if (div_mode) begin
                if (!diff[WIDTH])
                    acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                else
                    acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc <= {sum, acc[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/DIV unit owning the HI/LO registers.
// Define MULDIV_MADD_EN to add MADD/MADDU/MSUB/MSUBU (extra ACCUM state).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    muldiv_if.slave          bus,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    md_state_t state, state_next;

    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               op_mul, op_div, op_start;
    logic               sa, sb, dbz_in;
    logic [WIDTH-1:0]   mag_a, mag_b, iter_a;
    logic               load, step;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] fix_hl;
    logic [WIDTH-1:0]   q, r;
    logic               r_div, r_sa, r_sb, r_dbz;
`ifdef MULDIV_MADD_EN
    logic               op_acc, op_sub;
    logic               r_acc, r_sub;
    logic [2*WIDTH-1:0] prod;
`endif

    assign accept   = bus.op_valid & bus.op_ready;
    assign bus.op_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // Decode the presented op and prepare operand magnitudes.
    always_comb begin
        op_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
        op_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
`ifdef MULDIV_MADD_EN
        op_acc = (bus.op == OP_MADD) || (bus.op == OP_MADDU) ||
                 (bus.op == OP_MSUB) || (bus.op == OP_MSUBU);
        op_sub = (bus.op == OP_MSUB) || (bus.op == OP_MSUBU);
        op_start = op_mul | op_div | op_acc;
`else
        op_start = op_mul | op_div;
`endif
        sa     = op_signed(bus.op) & bus.a[WIDTH-1];
        sb     = op_signed(bus.op) & bus.b[WIDTH-1];
        mag_a  = sa ? -bus.a : bus.a;
        mag_b  = sb ? -bus.b : bus.b;
        dbz_in = op_div & (bus.b == '0);
        // Divide by zero reports the raw dividend in HI.
        iter_a = dbz_in ? bus.a : mag_a;
    end

    // MFHI/MFLO read port.
    always_comb begin
        bus.rd_data = '0;
        if (bus.op_valid) begin
            if (bus.op == OP_MFHI)
                bus.rd_data = hi;
            else if (bus.op == OP_MFLO)
                bus.rd_data = lo;
        end
    end

    // Sign correction of the raw magnitude result.
    always_comb begin
        q      = acc[WIDTH-1:0];
        r      = acc[2*WIDTH-1:WIDTH];
        fix_hl = (r_sa ^ r_sb) ? -acc : acc;
        if (r_div) begin
            if (r_dbz)
                fix_hl = {q, {WIDTH{1'b1}}};
            else
                fix_hl = {(r_sa ? -r : r),
                          ((r_sa ^ r_sb) ? -q : q)};
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept && op_start) begin
                    load       = 1'b1;
                    state_next = dbz_in ? S_FIXUP : S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(1))
                    state_next = S_FIXUP;
            end
            S_FIXUP: begin
`ifdef MULDIV_MADD_EN
                state_next = r_acc ? S_ACCUM : S_IDLE;
`else
                state_next = S_IDLE;
`endif
            end
            S_ACCUM: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // HI/LO, op context, step counter and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            r_div       <= 1'b0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_dbz       <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef MULDIV_MADD_EN
            r_acc       <= 1'b0;
            r_sub       <= 1'b0;
            prod        <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept && op_start) begin
                        cnt         <= CNT_W'(WIDTH);
                        r_div       <= op_div;
                        r_sa        <= sa;
                        r_sb        <= sb;
                        r_dbz       <= dbz_in;
                        div_by_zero <= 1'b0;
`ifdef MULDIV_MADD_EN
                        r_acc       <= op_acc;
                        r_sub       <= op_sub;
`endif
                    end else if (accept && bus.op == OP_MTHI) begin
                        hi <= bus.a;
                    end else if (accept && bus.op == OP_MTLO) begin
                        lo <= bus.a;
                    end
                end
                S_RUN: cnt <= cnt - CNT_W'(1);
                S_FIXUP: begin
`ifdef MULDIV_MADD_EN
                    if (r_acc) begin
                        prod <= fix_hl;
                    end else begin
                        {hi, lo} <= fix_hl;
                        done     <= 1'b1;
                    end
`else
                    {hi, lo} <= fix_hl;
                    done     <= 1'b1;
`endif
                    if (r_div && r_dbz)
                        div_by_zero <= 1'b1;
                end
                S_ACCUM: begin
`ifdef MULDIV_MADD_EN
                    {hi, lo} <= r_sub ? ({hi, lo} - prod)
                                      : ({hi, lo} + prod);
                    done     <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .step    (step),
        .is_div  (op_div),
        .op_a    (iter_a),
        .op_b    (mag_b),
        .acc     (acc)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + scoreboard bench for muldiv_unit.
// Covers MADD/MSUB when built with MULDIV_MADD_EN.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [31:0] hi, lo;
    logic        busy, done, div_by_zero;

    exp_t        sb_q[$];
    exp_t        e;
    int          tests = 0;
    int          fails = 0;
    int          lat, stale, ndone;
    logic [31:0] x, y;
    logic [63:0] p;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] va,
                         input logic [31:0] vb);
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.a        = va;
        bus.b        = vb;
    endtask

    // Hold the op until op_ready, then step past the accept edge.
    task automatic accept_wait();
        int n = 0;
        while (!bus.op_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_bound", 64'(n < 200), 64'(1));
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (!done && l < 200) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic check_res(input string tag, input int l, input exp_t ex);
        chk({tag, "_lat"}, 64'(l), 64'(ex.lat));
        chk({tag, "_hi"}, 64'(hi), 64'(ex.hi));
        chk({tag, "_lo"}, 64'(lo), 64'(ex.lo));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(ex.dbz));
    endtask

    task automatic muldiv(input string tag, input logic [3:0] o,
                          input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic ed, input int elat);
        exp_t ex;
        int   l;
        drive(o, va, vb);
        accept_wait();
        sb_q.push_back('{hi: eh, lo: el, dbz: ed, lat: elat});
        wait_done(l);
        ex = sb_q.pop_front();
        check_res(tag, l, ex);
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.op_valid = 1'b0;
        bus.op       = 4'd0;
        bus.a        = '0;
        bus.b        = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_dbz", 64'(div_by_zero), 64'(0));
        chk("rst_ready", 64'(bus.op_ready), 64'(1));
        reset_n = 1'b1;
        @(posedge clk); #1;

        muldiv("mult", OP_MULT, 32'hFFFF_FFFD, 32'd7,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
        @(posedge clk); #1;
        chk("done_pulse", 64'(done), 64'(0));
        muldiv("multu", OP_MULTU, 32'hFFFF_FFFD, 32'd7,
               32'h0000_0006, 32'hFFFF_FFEB, 1'b0, 33);
        muldiv("divu", OP_DIVU, 32'd100, 32'd7,
               32'd2, 32'd14, 1'b0, 33);
        muldiv("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
        muldiv("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000, 1'b0, 33);
        muldiv("div_zero", OP_DIV, 32'd5, 32'd0,
               32'd5, 32'hFFFF_FFFF, 1'b1, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("dbz_sticky", 64'(div_by_zero), 64'(1));

        drive(OP_MULT, 32'd2, 32'd3);
        accept_wait();
        chk("dbz_clear", 64'(div_by_zero), 64'(0));
        sb_q.push_back('{hi: 32'd0, lo: 32'd6, dbz: 1'b0, lat: 33});
        wait_done(lat);
        e = sb_q.pop_front();
        check_res("mult_small", lat, e);

        drive(OP_MTHI, 32'h1234, 32'd0);
        accept_wait();
        chk("mthi", 64'(hi), 64'h1234);
        drive(OP_MFHI, 32'd0, 32'd0);
        #1;
        chk("mfhi", 64'(bus.rd_data), 64'h1234);
        accept_wait();
        drive(OP_MTLO, 32'h5678, 32'd0);
        accept_wait();
        drive(OP_MFLO, 32'd0, 32'd0);
        #1;
        chk("mflo", 64'(bus.rd_data), 64'h5678);
        accept_wait();

        drive(4'hC, 32'hAAAA, 32'h1);
        #1;
        chk("undef_rd", 64'(bus.rd_data), 64'(0));
        accept_wait();
        chk("undef_hi", 64'(hi), 64'h1234);
        chk("undef_lo", 64'(lo), 64'h5678);
        chk("undef_busy", 64'(busy), 64'(0));

        drive(OP_MULTU, 32'd5, 32'd6);
        accept_wait();
        sb_q.push_back('{hi: 32'd0, lo: 32'd30, dbz: 1'b0, lat: 33});
        drive(OP_MFLO, 32'd0, 32'd0);
        #1;
        chk("mflo_busy_ready", 64'(bus.op_ready), 64'(0));
        @(posedge clk); #1;
        wait_done(lat);
        lat++;
        #1;
        chk("mflo_done_ready", 64'(bus.op_ready), 64'(1));
        chk("mflo_done_rd", 64'(bus.rd_data), 64'd30);
        e = sb_q.pop_front();
        check_res("mflo_mulu", lat, e);
        accept_wait();

        muldiv("b2b_divu", OP_DIVU, 32'd100, 32'd7,
               32'd2, 32'd14, 1'b0, 33);
        drive(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        accept_wait();
        chk("b2b_done_once", 64'(done), 64'(0));
        sb_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB,
                         dbz: 1'b0, lat: 33});
        stale = 0;
        lat = 0;
        while (!done && lat < 200) begin
            if (hi !== 32'd2 || lo !== 32'd14) stale++;
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_hold", 64'(stale), 64'(0));
        e = sb_q.pop_front();
        check_res("b2b_mult", lat, e);

        drive(OP_DIV, 32'd100, 32'd7);
        accept_wait();
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_hi", 64'(hi), 64'(0));
        chk("mid_rst_lo", 64'(lo), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("mid_rst_nodone", 64'(ndone), 64'(0));
        muldiv("post_rst", OP_DIVU, 32'd100, 32'd7,
               32'd2, 32'd14, 1'b0, 33);

        drive(OP_MTHI, 32'd0, 32'd0);
        accept_wait();
        drive(OP_MTLO, 32'd10, 32'd0);
        accept_wait();
`ifdef MULDIV_MADD_EN
        muldiv("madd", OP_MADD, 32'd3, 32'd4,
               32'd0, 32'd22, 1'b0, 34);
        muldiv("msub", OP_MSUB, 32'd2, 32'hFFFF_FFFD,
               32'd0, 32'd28, 1'b0, 34);
`else
        drive(OP_MADD, 32'd3, 32'd4);
        #1;
        chk("madd_off_rd", 64'(bus.rd_data), 64'(0));
        accept_wait();
        chk("madd_off_busy", 64'(busy), 64'(0));
        chk("madd_off_lo", 64'(lo), 64'd10);
`endif

        for (int i = 0; i < 4; i++) begin
            x = $urandom;
            y = $urandom_range(1, 100000);
            p = 64'(x) * 64'(y);
            muldiv("rnd_multu", OP_MULTU, x, y,
                   p[63:32], p[31:0], 1'b0, 33);
            muldiv("rnd_divu", OP_DIVU, x, y,
                   x % y, x / y, 1'b0, 33);
        end

        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
